// File: rtl/voice_envelope.sv
// voice_envelope: per-voice ADSR envelope, time-multiplexed one voice per clk during a tick-triggered scan.
// Levels, peaks and volumes are Q12.20 (1<<20 = full scale); a volume <= 0 is gate off.
module voice_envelope #(
  parameter int VOICES       = 8,
  parameter int ATTACK_STEP  = 1 << 18,
  parameter int DECAY_STEP   = 1 << 16,
  parameter int SUSTAIN_FRAC = 128,
  parameter int RELEASE_STEP = 1 << 17
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick_ce,
  input  logic [VOICES-1:0][31:0]  frequencies,
  input  logic [VOICES-1:0][31:0]  voice_volumes,
  output logic [VOICES-1:0][31:0]  env_levels,
  output logic [VOICES-1:0]        active,
  output logic                     busy,
  output logic                     overrun
);

  localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(VOICES - 1);
  localparam logic signed [32:0] ATK = 33'(ATTACK_STEP);
  localparam logic signed [32:0] DEC = 33'(DECAY_STEP);
  localparam logic signed [32:0] REL = 33'(RELEASE_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } env_state_t;

  env_state_t       state     [VOICES];
  logic [31:0]      peak      [VOICES];
  logic [31:0]      last_freq [VOICES];
  logic [IW-1:0]    idx;

  env_state_t       cur_state;
  env_state_t       eff_state;
  env_state_t       next_state;
  logic [31:0]      cur_level;
  logic [31:0]      cur_peak;
  logic [31:0]      cur_vol;
  logic [31:0]      cur_freq;
  logic [31:0]      eff_peak;
  logic [31:0]      next_level;
  logic             gate;
  logic             freq_chg;
  logic [63:0]      sustain_prod;
  logic signed [32:0] sustain;
  logic signed [32:0] level_ext;
  logic signed [32:0] peak_ext;
  logic signed [32:0] up_sum;
  logic signed [32:0] decay_sum;
  logic signed [32:0] release_sum;

  // Scan sequencer: a tick while idle starts a VOICES-clk scan; a tick while busy is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= tick_ce && busy;
      if (busy) begin
        if (idx == LAST_IDX) begin
          busy <= 1'b0;
          idx  <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end else if (tick_ce) begin
        busy <= 1'b1;
        idx  <= '0;
      end
    end
  end

  // Entry transitions resolve first so the new state's step lands on the same scan.
  always_comb begin
    cur_state = state[idx];
    cur_level = env_levels[idx];
    cur_peak  = peak[idx];
    cur_vol   = voice_volumes[idx];
    cur_freq  = frequencies[idx];
    gate      = $signed(cur_vol) > 32'sd0;
    freq_chg  = cur_freq != last_freq[idx];

    eff_state = cur_state;
    eff_peak  = cur_peak;
    case (cur_state)
      S_IDLE, S_RELEASE: begin
        if (gate) begin
          eff_state = S_ATTACK;
          eff_peak  = cur_vol;
        end
      end
      default: begin
        if (!gate) begin
          eff_state = S_RELEASE;
        end else if (freq_chg) begin
          eff_state = S_ATTACK;
          eff_peak  = cur_vol;
        end
      end
    endcase

    sustain_prod = 64'(eff_peak) * 64'(SUSTAIN_FRAC);
    sustain      = 33'(sustain_prod >> 8);
    level_ext    = $signed({1'b0, cur_level});
    peak_ext     = $signed({1'b0, eff_peak});
    up_sum       = level_ext + ATK;
    decay_sum    = level_ext - DEC;
    release_sum  = level_ext - REL;

    next_state = eff_state;
    next_level = cur_level;
    case (eff_state)
      S_ATTACK: begin
        if (up_sum >= peak_ext) begin
          next_level = eff_peak;
          next_state = S_DECAY;
        end else begin
          next_level = up_sum[31:0];
        end
      end
      S_DECAY: begin
        if (decay_sum <= sustain) begin
          next_level = sustain[31:0];
          next_state = S_SUSTAIN;
        end else begin
          next_level = decay_sum[31:0];
        end
      end
      S_RELEASE: begin
        if (release_sum <= 33'sd0) begin
          next_level = '0;
          next_state = S_IDLE;
        end else begin
          next_level = release_sum[31:0];
        end
      end
      default: begin
        next_level = cur_level;
      end
    endcase
  end

  // Only the voice under the scan index is written; all others hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < VOICES; v++) begin
        state[v]      <= S_IDLE;
        peak[v]       <= '0;
        last_freq[v]  <= '0;
        env_levels[v] <= '0;
      end
    end else if (busy) begin
      state[idx]      <= next_state;
      peak[idx]       <= eff_peak;
      last_freq[idx]  <= cur_freq;
      env_levels[idx] <= next_level;
    end
  end

  always_comb begin
    active = '0;
    for (int v = 0; v < VOICES; v++) begin
      active[v] = state[v] != S_IDLE;
    end
  end

endmodule

// File: tb/tb_voice_envelope.sv
// tb_voice_envelope: directed ADSR sequences on voices 0, 2, 3 and 4 with hand-computed levels,
// covering release/retrigger, frequency-change steal, overrun and mid-scan reset.
module tb_voice_envelope;

  localparam int VOICES = 8;
  localparam logic [31:0] FULL = 32'd1048576;
  localparam logic [31:0] HALF = 32'd524288;

  logic                    clk;
  logic                    reset;
  logic                    tick_ce;
  logic [VOICES-1:0][31:0] frequencies;
  logic [VOICES-1:0][31:0] voice_volumes;
  logic [VOICES-1:0][31:0] env_levels;
  logic [VOICES-1:0]       active;
  logic                    busy;
  logic                    overrun;

  int checks = 0;
  int passes = 0;

  voice_envelope #(.VOICES(VOICES)) dut (
    .clk(clk),
    .reset(reset),
    .tick_ce(tick_ce),
    .frequencies(frequencies),
    .voice_volumes(voice_volumes),
    .env_levels(env_levels),
    .active(active),
    .busy(busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // One tick, then wait (bounded) for the scan to finish.
  task automatic applyStimulus();
    int cyc;
    @(negedge clk);
    tick_ce = 1'b1;
    @(negedge clk);
    tick_ce = 1'b0;
    cyc = 0;
    while (busy && cyc < 4 * VOICES) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("scan_end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    tick_ce       = 1'b0;
    voice_volumes = '0;
    for (int v = 0; v < VOICES; v++) frequencies[v] = 32'h0010_0000 * (v + 1);
    repeat (2) @(negedge clk);
    checkOutput("rst_env0", env_levels[0], 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Attack to peak, decay to sustain on voices 0, 2, 3; voice 4 has a negative volume
    voice_volumes[0] = FULL;
    voice_volumes[2] = FULL;
    voice_volumes[3] = FULL;
    voice_volumes[4] = 32'hFFFF_FFFB;
    applyStimulus();
    checkOutput("atk1_env0", env_levels[0], 32'd262144);
    checkOutput("atk1_active0", 32'(active[0]), 32'd1);
    checkOutput("neg_vol_env4", env_levels[4], 32'd0);
    checkOutput("neg_vol_active4", 32'(active[4]), 32'd0);
    applyStimulus();
    checkOutput("atk2_env0", env_levels[0], 32'd524288);
    applyStimulus();
    checkOutput("atk3_env0", env_levels[0], 32'd786432);
    applyStimulus();
    checkOutput("atk4_env0", env_levels[0], 32'd1048576);
    applyStimulus();
    checkOutput("dec1_env0", env_levels[0], 32'd983040);
    repeat (7) applyStimulus();
    checkOutput("dec8_env0", env_levels[0], 32'd524288);
    checkOutput("dec8_env2", env_levels[2], 32'd524288);
    checkOutput("dec8_env3", env_levels[3], 32'd524288);
    applyStimulus();
    checkOutput("sus_hold_env0", env_levels[0], 32'd524288);
    checkOutput("sus_active0", 32'(active[0]), 32'd1);

    // Release voice 0 from sustain to idle
    voice_volumes[0] = 32'd0;
    applyStimulus();
    checkOutput("rel1_env0", env_levels[0], 32'd393216);
    applyStimulus();
    checkOutput("rel2_env0", env_levels[0], 32'd262144);
    applyStimulus();
    checkOutput("rel3_env0", env_levels[0], 32'd131072);
    applyStimulus();
    checkOutput("rel4_env0", env_levels[0], 32'd0);
    checkOutput("rel4_active0", 32'(active[0]), 32'd0);
    applyStimulus();
    checkOutput("idle_env0", env_levels[0], 32'd0);
    checkOutput("idle_active0", 32'(active[0]), 32'd0);
    checkOutput("idle_env2_hold", env_levels[2], 32'd524288);

    // Retrigger from release at 262144 without a dip
    voice_volumes[0] = FULL;
    applyStimulus();
    applyStimulus();
    checkOutput("re_atk_env0", env_levels[0], 32'd524288);
    voice_volumes[0] = 32'd0;
    applyStimulus();
    applyStimulus();
    checkOutput("re_rel_env0", env_levels[0], 32'd262144);
    voice_volumes[0] = FULL;
    applyStimulus();
    checkOutput("retrig_env0", env_levels[0], 32'd524288);
    checkOutput("retrig_active0", 32'(active[0]), 32'd1);
    applyStimulus();
    checkOutput("retrig2_env0", env_levels[0], 32'd786432);

    // Voice 2 stolen by a new frequency while in sustain
    frequencies[2] = 32'h0123_4567;
    applyStimulus();
    checkOutput("steal_env2", env_levels[2], 32'd786432);
    checkOutput("steal_env0", env_levels[0], 32'd1048576);
    applyStimulus();
    checkOutput("steal_peak_env2", env_levels[2], 32'd1048576);
    // Steal again with a lower volume: one-step clamp down to the new peak
    frequencies[2]   = 32'h0234_5678;
    voice_volumes[2] = HALF;
    applyStimulus();
    checkOutput("clamp_env2", env_levels[2], 32'd524288);
    applyStimulus();
    checkOutput("clamp_dec_env2", env_levels[2], 32'd458752);
    checkOutput("clamp_env3_hold", env_levels[3], 32'd524288);

    // Overrun: second tick on the 3rd busy clk is dropped
    @(negedge clk);
    tick_ce = 1'b1;
    @(negedge clk);
    tick_ce = 1'b0;
    checkOutput("ovr_busy_start", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("ovr_pre", 32'(overrun), 32'd0);
    @(negedge clk);
    tick_ce = 1'b1;
    @(negedge clk);
    tick_ce = 1'b0;
    checkOutput("ovr_pulse", 32'(overrun), 32'd1);
    @(negedge clk);
    checkOutput("ovr_pulse_end", 32'(overrun), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("ovr_busy_n8", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("ovr_busy_n9", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("ovr_no_rescan", 32'(busy), 32'd0);
    checkOutput("ovr_env2", env_levels[2], 32'd393216);
    checkOutput("ovr_env0", env_levels[0], 32'd786432);

    // Reset mid-scan with voice 3 still in sustain
    @(negedge clk);
    tick_ce = 1'b1;
    @(negedge clk);
    tick_ce = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    checkOutput("mid_env3", env_levels[3], 32'd524288);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_env3", env_levels[3], 32'd0);
    checkOutput("mid_rst_env0", env_levels[0], 32'd0);
    checkOutput("mid_rst_active", 32'(active), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    applyStimulus();
    checkOutput("post_rst_env3", env_levels[3], 32'd262144);
    checkOutput("post_rst_env2", env_levels[2], 32'd262144);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
